// File: rtl/sonar_pkg.sv
// Shared sonar definitions: FSM state codes and servo position codes.
// Reused by the sweep controller, the PWM stage and the measurement stage.
package sonar_pkg;

   typedef enum logic [3:0] {
      INICIAL   = 4'd0,
      POSICIONA = 4'd1,
      MEDE      = 4'd2,
      ESPERA    = 4'd3,
      AVANCA    = 4'd4
   } estado_t;

   localparam logic [1:0] POS_OFF = 2'b00;
   localparam logic [1:0] POS_ESQ = 2'b01;
   localparam logic [1:0] POS_CEN = 2'b10;
   localparam logic [1:0] POS_DIR = 2'b11;

   // Counter width able to hold the larger of the two phase lengths minus one.
   function automatic int largura_contador(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return (m <= 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/contador_m.sv
// Modulo counter with synchronous clear, enable and a run-time end-of-count
// value, so one instance can time phases of different lengths.
module contador_m #(
   parameter int N = 4
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         zera,
   input  logic         conta,
   input  logic [N-1:0] limite,
   output logic         fim
);

   logic [N-1:0] valor_reg;

   always_ff @(posedge clock) begin
      if (!reset || zera) begin
         valor_reg <= '0;
      end else if (conta) begin
         valor_reg <= (valor_reg == limite) ? '0 : valor_reg + N'(1);
      end
   end

   assign fim = (valor_reg == limite);

endmodule

// File: rtl/varredura_servo.sv
// Servo sweep controller: steps the servo across three positions, waits for it
// to settle, requests a sonar measurement and times out if none arrives.
module varredura_servo
   import sonar_pkg::*;
#(
   parameter int TEMPO_ASSENTAMENTO = 25000000,
   parameter int TIMEOUT_MEDIDA     = 2500000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       ligar,
   input  logic       fim_medida,
   output logic [1:0] posicao,
   output logic       medir,
   output logic       erro_medida,
   output logic [3:0] db_estado
);

   localparam int N = largura_contador(TEMPO_ASSENTAMENTO, TIMEOUT_MEDIDA);

   estado_t    estado_reg, estado_next;
   logic [1:0] posicao_reg, posicao_next;
   logic       sobe_reg, sobe_next;
   logic       medir_reg, medir_next;
   logic       erro_reg, erro_next;
   logic       zera, conta, fim_contagem;
   logic [N-1:0] limite;

   // The single counter times settling in POSICIONA and the timeout in ESPERA.
   assign limite = (estado_reg == ESPERA) ? N'(TIMEOUT_MEDIDA - 1)
                                          : N'(TEMPO_ASSENTAMENTO - 1);

   contador_m #(.N(N)) u_contador (
      .clock  (clock),
      .reset  (reset),
      .zera   (zera),
      .conta  (conta),
      .limite (limite),
      .fim    (fim_contagem)
   );

   always_comb begin
      estado_next  = estado_reg;
      posicao_next = posicao_reg;
      sobe_next    = sobe_reg;
      medir_next   = 1'b0;
      erro_next    = 1'b0;
      conta        = 1'b0;
      zera         = 1'b0;
      case (estado_reg)
         INICIAL: begin
            posicao_next = POS_OFF;
            if (ligar) begin
               estado_next  = POSICIONA;
               posicao_next = POS_ESQ;
               sobe_next    = 1'b1;
            end
         end
         POSICIONA: begin
            conta = 1'b1;
            if (fim_contagem) begin
               estado_next = MEDE;
               medir_next  = 1'b1;
            end
         end
         MEDE: begin
            estado_next = ESPERA;
         end
         ESPERA: begin
            conta = 1'b1;
            // A measurement arriving on the last timeout cycle still counts as success.
            if (fim_medida) begin
               estado_next = AVANCA;
            end else if (fim_contagem) begin
               estado_next = AVANCA;
               erro_next   = 1'b1;
            end
         end
         AVANCA: begin
            if (!ligar) begin
               estado_next  = INICIAL;
               posicao_next = POS_OFF;
            end else begin
               estado_next = POSICIONA;
               if (sobe_reg) begin
                  if (posicao_reg == POS_DIR) begin
                     sobe_next    = 1'b0;
                     posicao_next = POS_CEN;
                  end else begin
                     posicao_next = posicao_reg + 2'd1;
                  end
               end else begin
                  if (posicao_reg == POS_ESQ) begin
                     sobe_next    = 1'b1;
                     posicao_next = POS_CEN;
                  end else begin
                     posicao_next = posicao_reg - 2'd1;
                  end
               end
            end
         end
         default: begin
            estado_next  = INICIAL;
            posicao_next = POS_OFF;
            sobe_next    = 1'b1;
         end
      endcase
      zera = (estado_next != estado_reg);
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         estado_reg  <= INICIAL;
         posicao_reg <= POS_OFF;
         sobe_reg    <= 1'b1;
         medir_reg   <= 1'b0;
         erro_reg    <= 1'b0;
      end else begin
         estado_reg  <= estado_next;
         posicao_reg <= posicao_next;
         sobe_reg    <= sobe_next;
         medir_reg   <= medir_next;
         erro_reg    <= erro_next;
      end
   end

   assign posicao     = posicao_reg;
   assign medir       = medir_reg;
   assign erro_medida = erro_reg;
   assign db_estado   = estado_reg;

endmodule

// File: doc/varredura_servo.md
VARREDURA_SERVO -- requirements
Module: varredura_servo

Interface
REQ-001 The block SHALL have parameter TEMPO_ASSENTAMENTO, default 25000000, meaning the settle cycles at each position (0.5 s at 50 MHz); legal range is 2 or more.
REQ-002 The block SHALL have parameter TIMEOUT_MEDIDA, default 2500000, meaning the maximum cycles spent waiting for a measurement (50 ms); legal range is 2 or more.
REQ-003 The block SHALL have port clock, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset; reset=0 sampled on a rising clock edge resets the block.
REQ-005 The block SHALL have port ligar, input, 1 bit: sweep enable level.
REQ-006 The block SHALL have port fim_medida, input, 1 bit: one-cycle pulse from the ultrasonic measurement stage.
REQ-007 The block SHALL have port posicao, output, 2 bits: position code driven straight into the servo PWM stage; 00 means no pulse.
REQ-008 The block SHALL have port medir, output, 1 bit: one-cycle measurement-request pulse.
REQ-009 The block SHALL have port erro_medida, output, 1 bit: one-cycle pulse when a measurement times out.
REQ-010 The block SHALL have port db_estado, output, 4 bits: current FSM state code.

Function
REQ-011 The FSM SHALL have five states with these db_estado codes: INICIAL=0, POSICIONA=1, MEDE=2, ESPERA=3, AVANCA=4; all other codes SHALL be unreachable and SHALL recover to INICIAL on the next edge.
REQ-012 All outputs SHALL be registered, with no combinational path from an input to an output.
REQ-013 In INICIAL: posicao=00; when ligar=1, the FSM SHALL go to POSICIONA with posicao<=01, direction<=up, and the counter cleared.
REQ-014 In POSICIONA: the counter SHALL increment each cycle; when counter==TEMPO_ASSENTAMENTO-1, the FSM SHALL go to MEDE and clear the counter, so the FSM spends exactly TEMPO_ASSENTAMENTO cycles in POSICIONA.
REQ-015 In MEDE: medir=1 for exactly that one cycle; the next state SHALL be ESPERA.
REQ-016 In ESPERA: fim_medida=1 SHALL cause a transition to AVANCA; otherwise, when counter==TIMEOUT_MEDIDA-1, the FSM SHALL go to AVANCA and pulse erro_medida for one cycle.
REQ-017 If fim_medida and the final timeout cycle coincide, fim_medida SHALL win and erro_medida SHALL stay 0.
REQ-018 fim_medida SHALL be ignored in every state except ESPERA.
REQ-019 In AVANCA with ligar=0: the FSM SHALL go to INICIAL with posicao<=00.
REQ-020 In AVANCA with ligar=1: posicao SHALL step along 01,10,11,10,01,... as follows:
  - direction up, posicao=11: direction<=down and posicao<=10.
  - direction down, posicao=01: direction<=up and posicao<=10.
  - otherwise posicao<=posicao+1 (up) or posicao-1 (down).
  - next state SHALL be POSICIONA with the counter cleared.
REQ-021 A ligar deassertion outside INICIAL and AVANCA SHALL NOT abort the current position; the FSM SHALL stop at the next AVANCA.
REQ-022 posicao SHALL never be 00 outside INICIAL, and SHALL change only on the transitions into POSICIONA or INICIAL.
REQ-023 A single counter SHALL be sized to ceil(log2(max(TEMPO_ASSENTAMENTO,TIMEOUT_MEDIDA))) bits and SHALL NOT wrap during legal operation.

Reset
REQ-024 When reset=0 is sampled, the block SHALL on that edge set:
  - state to INICIAL;
  - posicao=00, medir=0, erro_medida=0, db_estado=0000;
  - counter to 0 and direction to up.
REQ-025 Reset SHALL override every other input in every state, including mid-ESPERA and mid-POSICIONA.
REQ-026 After reset is released, a sweep SHALL restart only when INICIAL samples ligar=1.

Structure
REQ-027 A shared sonar package SHALL hold the state codes (INICIAL..AVANCA) and the position constants POS_OFF=00, POS_ESQ=01, POS_CEN=10 and POS_DIR=11, for reuse by the PWM and measurement stages.
REQ-028 The block SHALL contain one sub-module, contador_m: a generic modulo counter with synchronous clear, enable and an end-of-count flag, shared between the settle and timeout phases.

Verification
All scenarios SHALL use TEMPO_ASSENTAMENTO=4 and TIMEOUT_MEDIDA=6.
REQ-029 Hold reset=0 for 2 cycles -> posicao=00, medir=0, erro_medida=0, db_estado=0.
REQ-030 Raise ligar=1 and keep it high, then issue fim_medida 3 cycles after medir -> state/posicao sequence:
  - posicao=01 for 4 cycles in state 1;
  - one cycle in state 2 with medir=1;
  - 3 cycles in state 3, then state 4;
  - posicao=10 on entry to POSICIONA.
REQ-031 Answer every medir with fim_medida -> posicao sequence across positions is 01,10,11,10,01,10, with no erro_medida.
REQ-032 Drive no fim_medida -> exactly 6 cycles in ESPERA, a one-cycle erro_medida pulse, then posicao advances normally.
REQ-033 Pulse fim_medida on the 6th ESPERA cycle -> erro_medida stays 0 and posicao advances.
REQ-034 Both of the following SHALL hold:
  - Drop ligar mid-POSICIONA at posicao=10 -> medir still pulses once, then after AVANCA the state is 0 and posicao=00.
  - Assert reset=0 mid-ESPERA -> state 0 and posicao=00 on the next edge; a late fim_medida is ignored.
